// File: rtl/sign_restore_pkg.sv
// Shared types and helpers for the bit-serial sign-magnitude to two's-complement
// converter. The optional saturation path is enabled by SIGN_RESTORE_SAT_EN.
package sign_restore_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Saturation value for a given sign: most positive (0 then all ones) or
    // most negative (1 then all zeros). Returned right-aligned in 32 bits.
    function automatic logic [31:0] sat_value(input logic sign, input int unsigned width);
        logic [31:0] one;
        logic [31:0] r;
        one = 32'd1;
        r   = one << (width - 32'd1);
        if (!sign) begin
            r = r - 32'd1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/sign_restore_serial_if.sv
// Handshake bundle for sign_restore_serial: input side (in_valid/in_ready,
// mag, sign) and output side (out_valid/out_ready, y, overflow).
interface sign_restore_serial_if #(
    parameter int WIDTH = sign_restore_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             overflow;

    // Producer/consumer side: drives the request and the output acceptance.
    modport master (
        output in_valid, mag, sign, out_ready,
        input  in_ready, out_valid, y, overflow
    );

    // Converter side.
    modport slave (
        input  in_valid, mag, sign, out_ready,
        output in_ready, out_valid, y, overflow
    );
endinterface

// File: rtl/serial_twos_cell.sv
// One-bit serial negation cell: bits pass unchanged until the first one has
// been seen, after which they are inverted when the sign requests negation.
module serial_twos_cell (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic b,
    input  logic sign,
    output logic out_bit
);
    logic seen_one;

    // Output bit mapping; the first one itself is copied, later bits flip.
    always_comb begin
        out_bit = b;
        if (sign && seen_one) begin
            out_bit = ~b;
        end else begin
            out_bit = b;
        end
    end

    // Remember whether a one has already gone past in this transaction.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | b;
        end else begin
            seen_one <= seen_one;
        end
    end
endmodule

// File: rtl/sign_restore_serial.sv
// Bit-serial sign-magnitude to two's-complement converter, LSB first.
// Optional macro SIGN_RESTORE_SAT_EN: saturate y on overflow instead of wrapping.
module sign_restore_serial
    import sign_restore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    sign_restore_serial_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             overflow;

    logic             load;
    logic             shift_en;
    logic             out_bit;
    logic             ovf_calc;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] y_final;
`ifdef SIGN_RESTORE_SAT_EN
    logic [31:0]      sat_full;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y         = y;
    assign bus.overflow  = overflow;

    // Accept and shift strobes, plus the overflow verdict for the incoming magnitude.
    always_comb begin
        load     = (state == IDLE) && bus.in_valid && in_ready;
        shift_en = (state == SHIFT);
        ovf_calc = bus.mag[WIDTH-1];
        if (bus.sign) begin
            ovf_calc = bus.mag[WIDTH-1] & (|bus.mag[WIDTH-2:0]);
        end else begin
            ovf_calc = bus.mag[WIDTH-1];
        end
    end

    serial_twos_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .clear   (load),
        .en      (shift_en),
        .b       (sr[0]),
        .sign    (sign_q),
        .out_bit (out_bit)
    );

    // Value the shift register will hold after the final shift, with optional saturation.
    always_comb begin
        shifted = {out_bit, sr[WIDTH-1:1]};
        y_final = shifted;
`ifdef SIGN_RESTORE_SAT_EN
        sat_full = sat_value(sign_q, WIDTH);
        if (overflow) begin
            y_final = sat_full[WIDTH-1:0];
        end else begin
            y_final = shifted;
        end
`endif
    end

    // Control FSM with shift register, counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= {WIDTH{1'b0}};
            cnt       <= {CNT_W{1'b0}};
            sign_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= {WIDTH{1'b0}};
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sr       <= bus.mag;
                        sign_q   <= bus.sign;
                        cnt      <= {CNT_W{1'b0}};
                        overflow <= ovf_calc;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sr  <= shifted;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        y         <= y_final;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sign_restore_serial.sv
// Self-checking bench for sign_restore_serial: directed cases, random vectors,
// backpressure, mid-operation reset and back-to-back throughput.
module tb_sign_restore_serial;
    localparam int W = 6;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sign_restore_serial_if #(.WIDTH(W)) bus ();

    sign_restore_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed range check on the requested value.
    function automatic bit model_ovf(input int m, input bit s);
        if (s) return (m > (1 << (W - 1)));
        return (m > ((1 << (W - 1)) - 1));
    endfunction

    // Reference: exact signed value truncated to W bits, or saturated when enabled.
    function automatic logic [W-1:0] model_y(input int m, input bit s);
        int v;
        v = s ? -m : m;
`ifdef SIGN_RESTORE_SAT_EN
        if (model_ovf(m, s)) begin
            if (s) v = -(1 << (W - 1));
            else   v = (1 << (W - 1)) - 1;
        end
`endif
        return v[W-1:0];
    endfunction

    // Run one transaction; returns result, flag and cycles from accept to out_valid.
    task automatic do_txn(input int m, input bit s, output logic [W-1:0] y_o,
                          output logic ovf_o, output int lat_o);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mag      = m[W-1:0];
        bus.sign     = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.mag      = W'($urandom);
        bus.sign     = 1'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        y_o   = bus.y;
        ovf_o = bus.overflow;
        lat_o = lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 6'd0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b y=%b ovf=%b, required 1 0 000000 0",
                     bus.in_ready, bus.out_valid, bus.y, bus.overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int mags[10]  = '{5, 5, 0, 32, 32, 40, 31, 63, 1, 33};
        bit signs[10] = '{0, 1, 1, 1, 0, 1, 0, 1, 1, 1};
        logic [W-1:0] yo;
        logic ov;
        int lat;
        for (int i = 0; i < 10; i++) begin
            do_txn(mags[i], signs[i], yo, ov, lat);
            n_vec++;
            if (yo !== model_y(mags[i], signs[i])) begin
                n_err++;
                $display("FAIL directed_y mag=%0d sign=%0d: got %b, required %b",
                         mags[i], signs[i], yo, model_y(mags[i], signs[i]));
            end
            n_vec++;
            if (ov !== model_ovf(mags[i], signs[i])) begin
                n_err++;
                $display("FAIL directed_ovf mag=%0d sign=%0d: got %b, required %b",
                         mags[i], signs[i], ov, model_ovf(mags[i], signs[i]));
            end
            n_vec++;
            if (lat !== W) begin
                n_err++;
                $display("FAIL directed_latency mag=%0d sign=%0d: got %0d, required %0d",
                         mags[i], signs[i], lat, W);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] yo;
        logic ov;
        int lat;
        int m;
        bit s;
        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(0, (1 << W) - 1));
            s = 1'($urandom_range(0, 1));
            do_txn(m, s, yo, ov, lat);
            n_vec++;
            if (yo !== model_y(m, s) || ov !== model_ovf(m, s) || lat !== W) begin
                n_err++;
                $display("FAIL random mag=%0d sign=%0d: got y=%b ovf=%b lat=%0d, required y=%b ovf=%b lat=%0d",
                         m, s, yo, ov, lat, model_y(m, s), model_ovf(m, s), W);
            end
        end
    endtask

    task automatic test_backpressure();
        int m;
        bit s;
        int lat;
        m = 40;
        s = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mag      = m[W-1:0];
        bus.sign     = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++;
        if (lat !== W) begin
            n_err++;
            $display("FAIL bp_latency: got %0d, required %0d", lat, W);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.mag      = W'($urandom);
            bus.sign     = 1'($urandom);
            @(posedge clk);
            #1;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.y !== model_y(m, s) || bus.overflow !== model_ovf(m, s)) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b y=%b ovf=%b, required 1 0 %b %b",
                         i, bus.out_valid, bus.in_ready, bus.y, bus.overflow, model_y(m, s), model_ovf(m, s));
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_no_capture: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] yo;
        logic ov;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mag      = 6'd40;
        bus.sign     = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== 6'd0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b y=%b ovf=%b, required 0 1 000000 0",
                     bus.out_valid, bus.in_ready, bus.y, bus.overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        do_txn(17, 1'b1, yo, ov, lat);
        n_vec++;
        if (yo !== 6'b101111 || ov !== 1'b0 || lat !== W) begin
            n_err++;
            $display("FAIL after_reset mag=17 sign=1: got y=%b ovf=%b lat=%0d, required y=101111 ovf=0 lat=%0d",
                     yo, ov, lat, W);
        end
    endtask

    task automatic test_back_to_back();
        int mq[5];
        bit sq[5];
        int k;
        for (int i = 0; i < 5; i++) begin
            mq[i] = int'($urandom_range(0, (1 << W) - 1));
            sq[i] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.mag       = mq[0][W-1:0];
        bus.sign      = sq[0];
        for (int e = 0; e < 32; e++) begin
            @(posedge clk);
            #1;
            k = e / (W + 2);
            n_vec++;
            if (bus.out_valid !== ((e % (W + 2)) == W) || bus.in_ready !== ((e % (W + 2)) == W + 1)) begin
                n_err++;
                $display("FAIL b2b_timing edge %0d: out_valid=%b in_ready=%b", e, bus.out_valid, bus.in_ready);
            end
            if ((e % (W + 2)) == W) begin
                n_vec++;
                if (bus.y !== model_y(mq[k], sq[k]) || bus.overflow !== model_ovf(mq[k], sq[k])) begin
                    n_err++;
                    $display("FAIL b2b_result txn %0d: got y=%b ovf=%b, required y=%b ovf=%b",
                             k, bus.y, bus.overflow, model_y(mq[k], sq[k]), model_ovf(mq[k], sq[k]));
                end
            end
            if ((e % (W + 2)) == 0) begin
                bus.mag  = mq[k + 1][W-1:0];
                bus.sign = sq[k + 1];
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mag       = 6'd0;
        bus.sign      = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
